mm_row_packer: RTL and testbench
================================

# mm_row_packer

Result-row packer placed directly downstream of the 16-lane floating-point dot-product unit in the matrix-multiply datapath. It takes the scalar dot-product stream (one DW-bit word per `add_valid` pulse), assembles `num` consecutive results into one packed output row, and buffers completed rows in a small FIFO for the write-back stage. The dot-product pipeline has no backpressure, so the packer also reports free buffer space (`free_rows`) to the issuer for throttling, and flags any loss as a sticky overflow. Data is treated as opaque bits; no arithmetic is performed on it.

## Interface
- `num`, 16, elements per row; must match the dot-product lane count.
- `DW`, 32, element width in bits (IEEE-754 single).
- `DEPTH`, 4, row FIFO depth; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  DW  dot-product result; connects to the dot-product unit's `matrix_vector_output`.
- `in_valid`  in  1  result valid; connects to the dot-product unit's `add_valid`. May be high on every cycle.
- `flush`  in  1  one-cycle pulse that closes a partially filled row.
- `row_data`  out  num*DW  head-of-FIFO row. Element k occupies bits [(k+1)*DW-1 : k*DW].
- `row_len`  out  $clog2(num+1)  number of valid elements in the head row, 1..num.
- `row_valid`  out  1  FIFO not empty.
- `row_ready`  in  1  consumer accepts the head row when `row_valid && row_ready`.
- `free_rows`  out  $clog2(DEPTH+1)  equals DEPTH minus the FIFO occupancy (registered).
- `overflow`  out  1  sticky. Set when a row is dropped; cleared only by `rst`.

## Operation
- Element index `idx` runs 0..num-1. Each `in_valid` cycle writes `in_data` into lane `idx` of the assembly register.
  - If `idx < num-1`, then `idx` increments.
  - If `idx == num-1`, the row is complete. The assembled row, including the current `in_data`, is pushed with `row_len = num`. `idx` wraps to 0 and the assembly register clears to zero.
- Flush, when `flush` is high:
  - With `in_valid` also high: the current element is written first. Then the row is pushed with `row_len = idx+1`.
  - With `in_valid` low and `idx > 0`: the row is pushed with `row_len = idx`.
  - With `in_valid` low and `idx == 0`: no operation.
  - In every push case, lanes at or beyond `row_len` are zero, and `idx` returns to 0.
- Push acceptance: a push is accepted if occupancy < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the row is dropped, `overflow` sets, and `idx` and the assembly register still reset to 0. The FIFO contents are unchanged.
- Pop: occurs when `row_valid && row_ready`. The head row advances.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Pop from an empty FIFO is ignored.
- FIFO storage:
  - Circular, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy counter of $clog2(DEPTH+1) bits.
  - Each entry holds num*DW data bits plus `row_len`.
- Output gating: `row_data` and `row_len` are 0 whenever `row_valid` is 0.
- Reset:
  - `idx` = 0, assembly register = 0, pointers = 0, occupancy = 0.
  - `row_valid` = 0, `row_data` = 0, `row_len` = 0, `free_rows` = DEPTH, `overflow` = 0.
  - A reset mid-row discards the partial row and all buffered rows, with no push.

## Timing
- Row latency: the last element (or flush) is sampled at edge T. The row is visible with `row_valid = 1` after edge T, i.e. during cycle T+1.
- Throughput: one element per cycle sustained. A row every num cycles never fills the FIFO if `row_ready` is held high.
- `free_rows` updates in the same edge as the push or pop that changes occupancy.
- Throttling contract for the issuer: a row may be started only while `free_rows` exceeds the number of rows already in flight in the dot-product pipeline. Overflow indicates a violation of this contract.
- `row_valid`, `row_data` and `row_len` remain stable while `row_valid && !row_ready`.

## Test plan
- Full row:
  - Stimulus: 16 consecutive `in_valid` cycles with `in_data = 0x3F800000 + k`, `row_ready` = 1.
  - Response: one cycle after the 16th sample, `row_valid` = 1, lane k = 0x3F800000 + k, `row_len` = 16, `free_rows` dips to 3 for one cycle then returns to 4.
- Gapped input:
  - Stimulus: the same 16 words with random idle cycles between them.
  - Response: identical row. No row is emitted before the 16th word.
- Flush:
  - Stimulus: 5 words 0xA..0xE, then a `flush` pulse on an idle cycle.
  - Response: `row_len` = 5, lanes 0..4 = 0xA..0xE, lanes 5..15 = 0.
  - Stimulus: a `flush` with `idx` = 0.
  - Response: no push.
- Backpressure and overflow:
  - Stimulus: `row_ready` = 0, 5 full rows.
  - Response: `free_rows` steps 4→0, 5th row dropped, `overflow` = 1 and sticky.
  - Stimulus: then `row_ready` = 1.
  - Response: exactly rows 1..4 drain in order.
- Full FIFO, simultaneous push and pop:
  - Stimulus: FIFO full, a 16th element arrives in the same cycle as a pop.
  - Response: push accepted, `overflow` stays 0, occupancy stays 4.
- Reset mid-row:
  - Stimulus: 7 elements plus 2 buffered rows, then `rst` for one cycle.
  - Response: `row_valid` = 0, `free_rows` = 4, `overflow` = 0. A subsequent 16-element row is emitted with lane 0 = first post-reset word.

Source files
------------

// File: rtl/mm_row_packer_if.sv
// Bus between the dot-product result stream, the row packer and the write-back consumer.
// The packer takes the slave side; the issuer/consumer takes the master side.
interface mm_row_packer_if #(
    parameter int num   = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    logic [DW-1:0]              in_data;
    logic                       in_valid;
    logic                       flush;
    logic [num*DW-1:0]          row_data;
    logic [$clog2(num+1)-1:0]   row_len;
    logic                       row_valid;
    logic                       row_ready;
    logic [$clog2(DEPTH+1)-1:0] free_rows;
    logic                       overflow;

    modport master (
        output in_data, in_valid, flush, row_ready,
        input  row_data, row_len, row_valid, free_rows, overflow
    );
    modport slave (
        input  in_data, in_valid, flush, row_ready,
        output row_data, row_len, row_valid, free_rows, overflow
    );
endinterface

// File: rtl/mm_row_packer.sv
// Packs the scalar dot-product stream into num-wide rows and buffers them in a
// DEPTH-entry circular FIFO; rows that find the FIFO full are dropped (sticky overflow).
module mm_row_packer #(
    parameter int num   = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    mm_row_packer_if.slave bus
);
    localparam int IW = $clog2(num);
    localparam int LW = $clog2(num+1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [num-1:0][DW-1:0] row_t;

    logic [IW-1:0] idx_q, idx_d;
    row_t          asm_q, asm_d, asm_w;
    row_t          mem_q [DEPTH];
    row_t          mem_d [DEPTH];
    logic [LW-1:0] len_q [DEPTH];
    logic [LW-1:0] len_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d, free_rows_q, free_rows_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, accept;
    logic [LW-1:0] push_len;

    always_comb begin
        asm_w = asm_q;
        if (bus.in_valid) asm_w[idx_q] = bus.in_data;

        push = (bus.in_valid && (idx_q == IW'(num-1) || bus.flush))
            || (!bus.in_valid && bus.flush && idx_q != '0);
        push_len = bus.in_valid ? LW'(idx_q) + LW'(1) : LW'(idx_q);
        pop      = (cnt_q != '0) && bus.row_ready;
        // A pop in the same cycle frees the slot even when the FIFO is full.
        accept   = push && (cnt_q != CW'(DEPTH) || pop);

        idx_d      = idx_q;
        asm_d      = asm_w;
        mem_d      = mem_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q + PW'(accept);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = overflow_q | (push && !accept);

        if (push) begin
            idx_d = '0;
            asm_d = '0;
            if (accept) begin
                mem_d[wr_ptr_q] = asm_w;
                len_d[wr_ptr_q] = push_len;
            end
        end else if (bus.in_valid) begin
            idx_d = idx_q + IW'(1);
        end

        cnt_d       = cnt_q + CW'(accept) - CW'(pop);
        free_rows_d = CW'(DEPTH) - cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            asm_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            free_rows_q <= CW'(DEPTH);
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            free_rows_q <= free_rows_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
            len_q       <= len_d;
        end
    end

    // Head-of-FIFO outputs read as zero while empty.
    assign bus.row_valid = (cnt_q != '0);
    assign bus.row_data  = bus.row_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.row_len   = bus.row_valid ? len_q[rd_ptr_q] : '0;
    assign bus.free_rows = free_rows_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mm_row_packer.sv
// Self-checking bench for mm_row_packer: directed scenarios plus random traffic
// against a queue-based model of rows, partial row and sticky overflow.
module tb_mm_row_packer;
    localparam int NUM   = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [NUM*DW-1:0] data;
        logic [4:0]        len;
    } mrow_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mrow_t         mq[$];
    logic [DW-1:0] part[$];
    bit            m_ovf;

    mm_row_packer_if #(.num(NUM), .DW(DW), .DEPTH(DEPTH)) bus ();
    mm_row_packer #(.num(NUM), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one cycle and advances the model with the same inputs.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        bit    full, do_pop, close;
        mrow_t nr;
        bus.in_valid = v; bus.in_data = d; bus.flush = f; bus.row_ready = r;
        full   = (mq.size() == DEPTH);
        do_pop = (mq.size() > 0) && r;
        if (v) part.push_back(d);
        close = (v && part.size() == NUM) || (f && part.size() > 0);
        if (do_pop) mq.delete(0);
        if (close) begin
            nr.data = '0;
            foreach (part[i]) nr.data[i*DW +: DW] = part[i];
            nr.len = 5'(part.size());
            if (!full || do_pop) mq.push_back(nr);
            else m_ovf = 1'b1;
            part.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.row_ready = 1'b0; bus.in_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); part.delete(); m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.row_valid); end
        checks++; if (bus.free_rows !== 3'(DEPTH)) begin errors++; $display("FAIL reset_free got %0d exp %0d", bus.free_rows, DEPTH); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.row_data !== '0 || bus.row_len !== '0) begin errors++; $display("FAIL reset_gate got len %0d exp 0", bus.row_len); end
    endtask

    task automatic test_full_row();
        logic [NUM*DW-1:0] exp;
        for (int k = 0; k < NUM; k++) exp[k*DW +: DW] = 32'h3F80_0000 + 32'(k);
        for (int k = 0; k < NUM; k++) begin
            drive(1'b1, 32'h3F80_0000 + 32'(k), 1'b0, 1'b1);
            if (k < NUM-1) begin
                checks++; if (bus.row_valid !== 1'b0) begin errors++; $display("FAIL full_early k=%0d got %b exp 0", k, bus.row_valid); end
            end
        end
        checks++; if (bus.row_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", bus.row_valid); end
        checks++; if (bus.row_data !== exp) begin errors++; $display("FAIL full_data got %h exp %h", bus.row_data, exp); end
        checks++; if (bus.row_len !== 5'd16) begin errors++; $display("FAIL full_len got %0d exp 16", bus.row_len); end
        checks++; if (bus.free_rows !== 3'd3) begin errors++; $display("FAIL full_free_dip got %0d exp 3", bus.free_rows); end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (bus.free_rows !== 3'd4 || bus.row_valid !== 1'b0) begin errors++; $display("FAIL full_free_back got %0d exp 4", bus.free_rows); end
    endtask

    task automatic test_gapped();
        logic [NUM*DW-1:0] exp;
        for (int k = 0; k < NUM; k++) exp[k*DW +: DW] = 32'h3F80_0000 + 32'(k);
        for (int k = 0; k < NUM; k++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                drive(1'b0, $urandom, 1'b0, 1'b1);
                checks++; if (bus.row_valid !== 1'b0) begin errors++; $display("FAIL gap_early k=%0d got %b exp 0", k, bus.row_valid); end
            end
            drive(1'b1, 32'h3F80_0000 + 32'(k), 1'b0, 1'b1);
        end
        checks++; if (bus.row_data !== exp || bus.row_len !== 5'd16) begin errors++; $display("FAIL gap_row got len %0d data %h exp %h", bus.row_len, bus.row_data, exp); end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        logic [NUM*DW-1:0] exp;
        exp = '0;
        for (int k = 0; k < 5; k++) begin
            exp[k*DW +: DW] = 32'hA + 32'(k);
            drive(1'b1, 32'hA + 32'(k), 1'b0, 1'b1);
        end
        checks++; if (bus.row_valid !== 1'b0) begin errors++; $display("FAIL flush_early got %b exp 0", bus.row_valid); end
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (bus.row_len !== 5'd5) begin errors++; $display("FAIL flush_len got %0d exp 5", bus.row_len); end
        checks++; if (bus.row_data !== exp) begin errors++; $display("FAIL flush_data got %h exp %h", bus.row_data, exp); end
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (bus.row_valid !== 1'b0 || bus.free_rows !== 3'd4) begin errors++; $display("FAIL flush_idle got valid %b free %0d exp 0/4", bus.row_valid, bus.free_rows); end
    endtask

    task automatic test_overflow();
        logic [NUM*DW-1:0] rows [5];
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < NUM; k++) begin
                rows[r][k*DW +: DW] = $urandom;
                drive(1'b1, rows[r][k*DW +: DW], 1'b0, 1'b0);
            end
            checks++; if (bus.free_rows !== 3'(r < 4 ? 3 - r : 0)) begin errors++; $display("FAIL ovf_free r=%0d got %0d exp %0d", r, bus.free_rows, r < 4 ? 3 - r : 0); end
            checks++; if (bus.overflow !== (r == 4)) begin errors++; $display("FAIL ovf_flag r=%0d got %b exp %b", r, bus.overflow, r == 4); end
        end
        for (int r = 0; r < 4; r++) begin
            checks++; if (bus.row_valid !== 1'b1 || bus.row_data !== rows[r]) begin errors++; $display("FAIL ovf_drain r=%0d got %h exp %h", r, bus.row_data, rows[r]); end
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        checks++; if (bus.row_valid !== 1'b0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_after got valid %b ovf %b exp 0/1", bus.row_valid, bus.overflow); end
    endtask

    task automatic test_full_simul();
        logic [NUM*DW-1:0] row1;
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < NUM; k++) begin
                logic [DW-1:0] w;
                w = $urandom;
                if (r == 1) row1[k*DW +: DW] = w;
                drive(1'b1, w, 1'b0, 1'b0);
            end
        for (int k = 0; k < NUM-1; k++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b1);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.free_rows !== 3'd0) begin errors++; $display("FAIL simul_free got %0d exp 0", bus.free_rows); end
        checks++; if (bus.row_data !== row1) begin errors++; $display("FAIL simul_head got %h exp %h", bus.row_data, row1); end
        for (int r = 0; r < 5; r++) begin
            checks++; if (bus.row_data !== (mq.size() > 0 ? mq[0].data : '0)) begin errors++; $display("FAIL simul_drain r=%0d got %h", r, bus.row_data); end
            drive(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] first;
        do_reset();
        for (int k = 0; k < 2*NUM + 7; k++) drive(1'b1, $urandom, 1'b0, 1'b0);
        do_reset();
        checks++; if (bus.row_valid !== 1'b0 || bus.free_rows !== 3'd4 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_state got valid %b free %0d ovf %b exp 0/4/0", bus.row_valid, bus.free_rows, bus.overflow); end
        first = $urandom;
        drive(1'b1, first, 1'b0, 1'b1);
        for (int k = 1; k < NUM; k++) drive(1'b1, $urandom, 1'b0, 1'b1);
        checks++; if (bus.row_valid !== 1'b1 || bus.row_data[DW-1:0] !== first) begin errors++; $display("FAIL rstmid_lane0 got %h exp %h", bus.row_data[DW-1:0], first); end
        checks++; if (bus.row_data !== mq[0].data || bus.row_len !== mq[0].len) begin errors++; $display("FAIL rstmid_row got %h exp %h", bus.row_data, mq[0].data); end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
            checks++;
            if (bus.row_valid !== (mq.size() > 0) || bus.free_rows !== 3'(DEPTH - mq.size()) || bus.overflow !== m_ovf
                || bus.row_data !== (mq.size() > 0 ? mq[0].data : '0) || bus.row_len !== (mq.size() > 0 ? mq[0].len : 5'd0)) begin
                errors++;
                $display("FAIL rand c=%0d got v%b f%0d o%b len%0d exp v%b f%0d o%b", c, bus.row_valid, bus.free_rows, bus.overflow, bus.row_len,
                         mq.size() > 0, DEPTH - mq.size(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_row();
        test_gapped();
        test_flush();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
